// File: rtl/alu_issue_stage.sv
// ID/EX issue stage for the 32-bit ALU: decodes RV32I op fields into G_Select, forwards
// operands and registers them behind a valid/ready handshake with load-use bubble insertion.
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic              mem_fwd_valid,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_fwd_valid,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        alu_g_select,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    output logic              out_is_load,
    output logic              out_is_store,
    output logic [XLEN-1:0]   out_store_data,
    output logic              out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // state  | meaning
    // EMPTY  | output register holds nothing valid
    // FULL   | output register holds an instruction for execute
    // BUBBLE | one dead cycle while a load result becomes forwardable
    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_BUBBLE} state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [2:0]      dec_g;
    logic            dec_illegal, dec_is_load, dec_is_store, dec_reads_rs1, dec_reads_rs2;
    logic [XLEN-1:0] dec_a, dec_b;
    logic            hazard, accept;

    logic [2:0]        alu_g_select_q, alu_g_select_d;
    logic [XLEN-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d, out_store_data_q, out_store_data_d;
    logic [REG_AW-1:0] out_rd_q, out_rd_d;
    logic              out_reg_write_q, out_reg_write_d;
    logic              out_is_load_q, out_is_load_d;
    logic              out_is_store_q, out_is_store_d;
    logic              out_illegal_q, out_illegal_d;

    // MEM beats WB beats the register file; x0 is hardwired to zero
    assign rs1_fwd = (in_rs1_addr == '0) ? '0 :
                     (mem_fwd_valid && mem_fwd_rd == in_rs1_addr) ? mem_fwd_data :
                     (wb_fwd_valid && wb_fwd_rd == in_rs1_addr) ? wb_fwd_data : in_rs1_data;
    assign rs2_fwd = (in_rs2_addr == '0) ? '0 :
                     (mem_fwd_valid && mem_fwd_rd == in_rs2_addr) ? mem_fwd_data :
                     (wb_fwd_valid && wb_fwd_rd == in_rs2_addr) ? wb_fwd_data : in_rs2_data;

    always_comb begin
        dec_g         = 3'b000;
        dec_illegal   = 1'b0;
        dec_is_load   = 1'b0;
        dec_is_store  = 1'b0;
        dec_reads_rs1 = 1'b1;
        dec_reads_rs2 = 1'b0;
        dec_a         = rs1_fwd;
        dec_b         = in_imm;
        case (in_opcode)
            OPC_OP: begin
                dec_reads_rs2 = 1'b1;
                dec_b         = rs2_fwd;
                case (in_funct3)
                    3'b000:  dec_g = {2'b00, in_funct7b5};
                    3'b100:  dec_g = 3'b010;
                    3'b110:  dec_g = 3'b100;
                    3'b111:  dec_g = 3'b110;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                case (in_funct3)
                    3'b000:  dec_g = 3'b000;
                    3'b100:  dec_g = 3'b010;
                    3'b110:  dec_g = 3'b100;
                    3'b111:  dec_g = 3'b110;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_LOAD:  dec_is_load = 1'b1;
            OPC_STORE: begin
                dec_is_store  = 1'b1;
                dec_reads_rs2 = 1'b1;
            end
            OPC_JALR: dec_g = 3'b000;
            OPC_LUI: begin
                dec_reads_rs1 = 1'b0;
                dec_a         = '0;
            end
            OPC_AUIPC: begin
                dec_reads_rs1 = 1'b0;
                dec_a         = in_pc;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign hazard = (state_q == S_FULL) && out_is_load_q && (out_rd_q != '0) &&
                    ((dec_reads_rs1 && in_rs1_addr == out_rd_q) ||
                     (dec_reads_rs2 && in_rs2_addr == out_rd_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (accept) state_d = S_FULL;
            S_FULL: begin
                if (out_ready) begin
                    if (accept)                  state_d = S_FULL;
                    else if (in_valid && hazard) state_d = S_BUBBLE;
                    else                         state_d = S_EMPTY;
                end
            end
            S_BUBBLE: state_d = S_EMPTY;
            default:  state_d = S_EMPTY;
        endcase
        if (flush) state_d = S_EMPTY;
    end

    always_comb begin
        out_valid = (state_q == S_FULL);
        in_ready  = (state_q != S_BUBBLE) && (!out_valid || out_ready) && !hazard && !flush;
        accept    = in_valid && in_ready;
    end

    always_comb begin
        alu_g_select_d   = alu_g_select_q;
        alu_a_d          = alu_a_q;
        alu_b_d          = alu_b_q;
        out_rd_d         = out_rd_q;
        out_reg_write_d  = out_reg_write_q;
        out_is_load_d    = out_is_load_q;
        out_is_store_d   = out_is_store_q;
        out_store_data_d = out_store_data_q;
        out_illegal_d    = out_illegal_q;
        if (accept) begin
            alu_g_select_d   = dec_illegal ? 3'b000 : dec_g;
            alu_a_d          = dec_a;
            alu_b_d          = dec_b;
            out_rd_d         = in_rd_addr;
            out_reg_write_d  = !dec_illegal && !dec_is_store && (in_rd_addr != '0);
            out_is_load_d    = dec_is_load;
            out_is_store_d   = dec_is_store;
            out_store_data_d = rs2_fwd;
            out_illegal_d    = dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_g_select_q   <= '0;
            alu_a_q          <= '0;
            alu_b_q          <= '0;
            out_rd_q         <= '0;
            out_reg_write_q  <= 1'b0;
            out_is_load_q    <= 1'b0;
            out_is_store_q   <= 1'b0;
            out_store_data_q <= '0;
            out_illegal_q    <= 1'b0;
        end else begin
            alu_g_select_q   <= alu_g_select_d;
            alu_a_q          <= alu_a_d;
            alu_b_q          <= alu_b_d;
            out_rd_q         <= out_rd_d;
            out_reg_write_q  <= out_reg_write_d;
            out_is_load_q    <= out_is_load_d;
            out_is_store_q   <= out_is_store_d;
            out_store_data_q <= out_store_data_d;
            out_illegal_q    <= out_illegal_d;
        end
    end

    assign alu_g_select   = alu_g_select_q;
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign out_rd         = out_rd_q;
    assign out_reg_write  = out_reg_write_q;
    assign out_is_load    = out_is_load_q;
    assign out_is_store   = out_is_store_q;
    assign out_store_data = out_store_data_q;
    assign out_illegal    = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level reference model of the issue register.
module tb_alu_issue_stage;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_ready, in_funct7b5;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [31:0] in_pc, in_imm, in_rs1_data, in_rs2_data;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic        mem_fwd_valid, wb_fwd_valid;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        out_valid, out_ready;
    logic [2:0]  alu_g_select;
    logic [31:0] alu_a, alu_b, out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_is_load, out_is_store, out_illegal;

    alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_g_select(alu_g_select), .alu_a(alu_a), .alu_b(alu_b),
        .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_store_data(out_store_data), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [2:0]  g;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        st;
        logic        ill;
    } fields_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the issue register: what execute should see, and whether a bubble is pending
    bit      m_valid;
    bit      m_bubble;
    fields_t m_f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_src(input logic [4:0] addr, input logic [31:0] rf);
        if (addr == 5'd0) return 32'd0;
        if (mem_fwd_valid && mem_fwd_rd == addr) return mem_fwd_data;
        if (wb_fwd_valid && wb_fwd_rd == addr) return wb_fwd_data;
        return rf;
    endfunction

    // ALU op for a register/immediate arithmetic instruction: -1 = unsupported
    // 0 add, 1 sub, 2 xor, 3 or, 4 and
    function automatic int ref_arith(input logic [2:0] f3, input bit allow_sub, input logic f7);
        case (f3)
            3'b000:  return (allow_sub && f7) ? 1 : 0;
            3'b100:  return 2;
            3'b110:  return 3;
            3'b111:  return 4;
            default: return -1;
        endcase
    endfunction

    function automatic fields_t ref_dec();
        fields_t f;
        int      kind;
        logic [1:0] mux;
        f    = '0;
        kind = 0;
        f.a  = ref_src(in_rs1_addr, in_rs1_data);
        f.b  = in_imm;
        f.sd = ref_src(in_rs2_addr, in_rs2_data);
        f.rd = in_rd_addr;
        if (in_opcode == OP) begin
            kind = ref_arith(in_funct3, 1'b1, in_funct7b5);
            f.b  = ref_src(in_rs2_addr, in_rs2_data);
        end else if (in_opcode == OPIMM) begin
            kind = ref_arith(in_funct3, 1'b0, in_funct7b5);
        end else if (in_opcode == LOAD) begin
            f.ld = 1'b1;
        end else if (in_opcode == STORE) begin
            f.st = 1'b1;
        end else if (in_opcode == LUI) begin
            f.a = 32'd0;
        end else if (in_opcode == AUIPC) begin
            f.a = in_pc;
        end else if (in_opcode != JALR) begin
            kind = -1;
        end
        f.ill = (kind < 0);
        mux   = (kind == 2) ? 2'd1 : (kind == 3) ? 2'd2 : (kind == 4) ? 2'd3 : 2'd0;
        f.g   = f.ill ? 3'b000 : {mux, (kind == 1)};
        f.rw  = !f.ill && !f.st && (in_rd_addr != 5'd0);
        return f;
    endfunction

    function automatic bit ref_hazard();
        bit r1, r2;
        r1 = !(in_opcode == LUI || in_opcode == AUIPC);
        r2 = (in_opcode == OP || in_opcode == STORE);
        return m_valid && m_f.ld && (m_f.rd != 5'd0) &&
               ((r1 && in_rs1_addr == m_f.rd) || (r2 && in_rs2_addr == m_f.rd));
    endfunction

    // Called just after a rising edge with inputs already set; advances one clock.
    task automatic cycle();
        bit      hz, exp_rdy, acc, nv, nb;
        fields_t nf;
        #2;
        hz      = ref_hazard();
        exp_rdy = !m_bubble && (!m_valid || out_ready) && !hz && !flush;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = in_valid && exp_rdy;
        nf  = m_f;
        if (rst) begin
            nv = 1'b0;
            nb = 1'b0;
            nf = '0;
        end else begin
            if (acc) nf = ref_dec();
            nb = !flush && m_valid && out_ready && in_valid && hz;
            nv = acc || (m_valid && !out_ready && !flush);
        end
        @(posedge clk);
        #1;
        m_valid  = nv;
        m_bubble = nb;
        m_f      = nf;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("g_select", 32'(alu_g_select), 32'(m_f.g));
        check("alu_a", alu_a, m_f.a);
        check("alu_b", alu_b, m_f.b);
        check("store_data", out_store_data, m_f.sd);
        check("out_rd", 32'(out_rd), 32'(m_f.rd));
        check("reg_write", 32'(out_reg_write), 32'(m_f.rw));
        check("is_load", 32'(out_is_load), 32'(m_f.ld));
        check("is_store", 32'(out_is_store), 32'(m_f.st));
        check("illegal", 32'(out_illegal), 32'(m_f.ill));
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        in_valid    = 1'b1;
        in_opcode   = op;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_rd_addr  = rd;
        in_rs1_addr = rs1;
        in_rs2_addr = rs2;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_imm      = imm;
        in_pc       = 32'h0000_1000;
    endtask

    task automatic no_fwd();
        mem_fwd_valid = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
        wb_fwd_valid  = 1'b0; wb_fwd_rd  = '0; wb_fwd_data  = '0;
    endtask

    initial begin
        logic [31:0] held_a;
        m_valid = 1'b0; m_bubble = 1'b0; m_f = '0;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        in_valid = 1'b0;
        no_fwd();
        cycle();
        cycle();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_gsel", 32'(alu_g_select), 32'd0);
        rst = 1'b0;

        drive(OP, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0);
        cycle();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_gsel", 32'(alu_g_select), 32'd0);
        check("add_a", alu_a, 32'd5);
        check("add_b", alu_b, 32'd7);
        check("add_rd", 32'(out_rd), 32'd3);
        check("add_rw", 32'(out_reg_write), 32'd1);

        drive(OP, 3'b000, 1'b1, 5'd4, 5'd1, 5'd2, 32'h10, 32'h20, 32'd0);
        cycle();
        check("sub_gsel", 32'(alu_g_select), 32'd1);
        check("sub_a", alu_a, 32'h10);
        check("sub_b", alu_b, 32'h20);

        drive(OPIMM, 3'b111, 1'b1, 5'd5, 5'd1, 5'd0, 32'h3, 32'd0, 32'hFFFF_FFF0);
        cycle();
        check("andi_gsel", 32'(alu_g_select), 32'd6);
        check("andi_b", alu_b, 32'hFFFF_FFF0);

        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'hAA;
        wb_fwd_valid  = 1'b1; wb_fwd_rd  = 5'd4; wb_fwd_data  = 32'hBB;
        drive(OP, 3'b000, 1'b0, 5'd7, 5'd4, 5'd2, 32'h11, 32'h22, 32'd0);
        cycle();
        check("fwd_mem_a", alu_a, 32'hAA);
        mem_fwd_rd = 5'd0; mem_fwd_data = 32'h55; wb_fwd_valid = 1'b0;
        drive(OP, 3'b000, 1'b0, 5'd7, 5'd0, 5'd2, 32'h77, 32'h22, 32'd0);
        cycle();
        check("fwd_x0_a", alu_a, 32'd0);
        no_fwd();

        // load-use: LW x5 then ADD x6,x5,x1
        drive(LOAD, 3'b010, 1'b0, 5'd5, 5'd1, 5'd0, 32'h100, 32'd0, 32'd4);
        cycle();
        check("lw_is_load", 32'(out_is_load), 32'd1);
        drive(OP, 3'b000, 1'b0, 5'd6, 5'd5, 5'd1, 32'hDEAD, 32'd3, 32'd0);
        #1 check("hz_in_ready", 32'(in_ready), 32'd0);
        cycle();
        check("bubble_valid", 32'(out_valid), 32'd0);
        #1 check("bubble_in_ready", 32'(in_ready), 32'd0);
        cycle();
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'h1234;
        #1 check("post_bubble_ready", 32'(in_ready), 32'd1);
        cycle();
        check("lu_valid", 32'(out_valid), 32'd1);
        check("lu_a", alu_a, 32'h1234);
        check("lu_rd", 32'(out_rd), 32'd6);
        no_fwd();

        // back-pressure on XOR, then OR transfers with no gap
        drive(OP, 3'b100, 1'b0, 5'd8, 5'd1, 5'd2, 32'hF0F0, 32'h0FF0, 32'd0);
        cycle();
        held_a = alu_a;
        check("xor_gsel", 32'(alu_g_select), 32'd2);
        out_ready = 1'b0;
        drive(OP, 3'b110, 1'b0, 5'd9, 5'd2, 5'd3, 32'h1, 32'h2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_in_ready", 32'(in_ready), 32'd0);
            cycle();
            check("stall_gsel", 32'(alu_g_select), 32'd2);
            check("stall_a", alu_a, 32'hF0F0);
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        cycle();
        check("or_valid", 32'(out_valid), 32'd1);
        check("or_gsel", 32'(alu_g_select), 32'd4);

        flush = 1'b1;
        drive(OP, 3'b111, 1'b0, 5'd10, 5'd1, 5'd2, 32'h1, 32'h2, 32'd0);
        cycle();
        check("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;

        drive(SYSTEM, 3'b000, 1'b0, 5'd9, 5'd1, 5'd2, 32'h1, 32'h2, 32'd0);
        cycle();
        check("ill_flag", 32'(out_illegal), 32'd1);
        check("ill_rw", 32'(out_reg_write), 32'd0);

        // reset while in BUBBLE
        drive(LOAD, 3'b010, 1'b0, 5'd5, 5'd1, 5'd0, 32'h100, 32'd0, 32'd4);
        cycle();
        drive(OP, 3'b000, 1'b0, 5'd6, 5'd5, 5'd1, 32'h1, 32'h2, 32'd0);
        cycle();
        check("pre_rst_bubble", 32'(out_valid), 32'd0);
        rst = 1'b1;
        in_valid = 1'b0;
        cycle();
        rst = 1'b0;
        check("rst_bub_valid", 32'(out_valid), 32'd0);
        check("rst_bub_gsel", 32'(alu_g_select), 32'd0);
        check("rst_bub_rd", 32'(out_rd), 32'd0);
        check("rst_bub_load", 32'(out_is_load), 32'd0);
        #1 check("rst_bub_ready", 32'(in_ready), 32'd1);
        cycle();

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [6:0] ops [9];
            ops = '{OP, OP, OPIMM, LOAD, LOAD, STORE, JALR, LUI, AUIPC};
            drive(ops[$urandom_range(0, 8)], 3'($urandom), 1'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom, $urandom, $urandom);
            if ($urandom_range(0, 19) == 0) in_opcode = 7'($urandom);
            in_pc         = $urandom;
            in_valid      = ($urandom_range(0, 9) < 8);
            out_ready     = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 19) == 0);
            rst           = ($urandom_range(0, 99) == 0);
            mem_fwd_valid = 1'($urandom);
            mem_fwd_rd    = 5'($urandom_range(0, 7));
            mem_fwd_data  = $urandom;
            wb_fwd_valid  = 1'($urandom);
            wb_fwd_rd     = 5'($urandom_range(0, 7));
            wb_fwd_data   = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX pipeline stage that feeds the 32-bit ALU. It decodes RV32I opcode/funct fields into the ALU's 3-bit G_Select, selects and forwards operands A/B, and registers them toward the execute stage. It uses a valid/ready handshake and detects load-use hazards, inserting a one-cycle bubble. Flush support covers branch redirects.

Parameters:
XLEN, 32, datapath width of operands, immediate, PC and forwarded data.
REG_AW, 5, register address width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  drop the held and incoming instruction.
in_valid  in  1  decode stage presents an instruction.
in_ready  out  1  stage accepts this cycle (combinational).
in_opcode  in  7  instr[6:0].
in_funct3  in  3  instr[14:12].
in_funct7b5  in  1  instr[30].
in_pc  in  XLEN  instruction PC.
in_imm  in  XLEN  sign-extended immediate, already formatted.
in_rs1_addr, in_rs2_addr, in_rd_addr  in  REG_AW each  register indices.
in_rs1_data, in_rs2_data  in  XLEN each  register-file read data.
mem_fwd_valid  in  1  MEM stage writes a register.
mem_fwd_rd  in  REG_AW  MEM destination.
mem_fwd_data  in  XLEN  MEM result.
wb_fwd_valid, wb_fwd_rd, wb_fwd_data  in  1/REG_AW/XLEN  WB equivalents.
out_valid  out  1  registered instruction valid.
out_ready  in  1  execute stage accepts.
alu_g_select  out  3  ALU op: bit0 = carry-in/subtract, bits[2:1] = result mux (00 sum, 01 xor, 10 or, 11 and).
alu_a, alu_b  out  XLEN each  ALU operands.
out_rd  out  REG_AW  destination register.
out_reg_write  out  1  writes rd (rd≠0, not store/illegal).
out_is_load, out_is_store  out  1 each  memory class.
out_store_data  out  XLEN  forwarded rs2 for stores.
out_illegal  out  1  unsupported opcode/funct.

Behaviour:
- Reset: every output register clears to 0 (out_valid=0, alu_g_select=000). The state machine goes to EMPTY. rst overrides flush and handshake.
- Decode:
  - OP (0110011): f3=000 gives ADD (000), or SUB (001) when f7b5=1. f3=100 gives 010, 110 gives 100, 111 gives 110.
  - OP-IMM (0010011): same f3 map, f7b5 ignored, never SUB.
  - LOAD (0000011), STORE (0100011), JALR (1100111): 000.
  - LUI: A=0, B=imm, 000. AUIPC: A=pc, B=imm, 000.
  - Anything else, including SLT/shift f3 values: out_illegal=1, out_reg_write=0, g_select=000.
- Operands: A=rs1 and B=rs2 for OP; B=imm for OP-IMM/LOAD/STORE/JALR.
- Forwarding, evaluated at capture with priority MEM > WB > regfile. A source matches only if valid, rd≠0 and rd==rsX. Address 0 always reads 0.
- Handshake: transfer out when out_valid & out_ready. in_ready = (!out_valid | out_ready) & !hazard & !flush. The output register loads only on an input transfer; otherwise it holds all fields stable while out_valid & !out_ready.
- Load-use hazard: the held or outgoing instruction is a LOAD with rd≠0, and the incoming instruction reads that rd as rs1 (any class) or rs2 (OP/STORE). LUI/AUIPC read no sources.
- States:
  - EMPTY: out_valid=0. Accept goes to FULL.
  - FULL: out_valid=1. Stay FULL when out_ready and in accepted. Go to EMPTY when out_ready and no input. Go to BUBBLE when out_ready and hazard.
  - BUBBLE: out_valid=0 for exactly one cycle, in_ready=0. Then go to EMPTY; the pending instruction is accepted next cycle with forwarded load data.
- Flush: next cycle out_valid=0 and state=EMPTY. A same-cycle in_valid is discarded; BUBBLE is abandoned.
- Simultaneous out_ready and input transfer: the new instruction replaces the old in the same edge with no bubble (full throughput).

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, g_select=000, A=5, B=7, out_rd=3, reg_write=1.
- SUB with f7b5=1, rs1=0x10, rs2=0x20 → g_select=001. ANDI imm=0xFFFFFFF0 → g_select=110, B=0xFFFFFFF0.
- rs1=x4 with MEM fwd (x4, 0xAA) and WB fwd (x4, 0xBB) → A=0xAA. rs1=x0 with MEM fwd rd=0 data 0x55 → A=0.
- LW x5 accepted, then ADD x6,x5,x1 → one cycle with out_valid=0 and in_ready=0, then ADD issues with WB/MEM-forwarded x5.
- out_ready=0 for 3 cycles while holding XOR → all outputs constant, in_ready=0. Then out_ready=1 → next instruction transfers with no gap.
- flush asserted with in_valid=1 in FULL → next cycle out_valid=0. Opcode 1110011 → out_illegal=1, reg_write=0. rst mid-BUBBLE → EMPTY, outputs zero.
